// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined control decode with load-use stall, branch flush and stall counter
// Optional JAL/JALR/LUI/AUIPC decodes enabled by defining CTRL_EXT_OPS_EN.
module pipe_ctrl_unit #(
  parameter int REG_W    = 5,
  parameter int ALU_OP_W = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [6:0]          id_opcode,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                ex_br_taken,
  output logic                stall,
  output logic                flush_if_id,
  output logic                id_illegal,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_alu_src,
  output logic                ex_branch_en,
  output logic                ex_jump_en,
  output logic                ex_mem_read,
  output logic [REG_W-1:0]    ex_rd,
  output logic                mem_read_en,
  output logic                mem_write_en,
  output logic                wb_reg_write,
  output logic [1:0]          wb_sel,
  output logic [REG_W-1:0]    wb_rd,
  output logic [CNT_W-1:0]    stall_cnt
);
  typedef struct packed {
    logic                reg_write;
    logic                alu_src;
    logic                branch;
    logic                jump;
    logic                mem_read;
    logic                mem_write;
    logic [1:0]          wb_sel;
    logic [ALU_OP_W-1:0] alu_op;
    logic [REG_W-1:0]    rd;
  } ctrl_t;
  ctrl_t dec, id_ex;
  logic legal, use_rs1, use_rs2, hazard;
  logic em_reg_write;
  logic [1:0] em_wb_sel;
  logic [REG_W-1:0] em_rd;
  always_comb begin
    dec = '0;
    legal = 1'b1;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (id_opcode)
      7'b0110011: begin dec.reg_write = 1'b1; dec.alu_op = ALU_OP_W'(2'b10); use_rs2 = 1'b1; end
      7'b0010011: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_OP_W'(2'b11); end
      7'b0000011: begin dec.mem_read = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.wb_sel = 2'b01; end
      7'b0100011: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; use_rs2 = 1'b1; end
      7'b1100011: begin dec.branch = 1'b1; dec.alu_op = ALU_OP_W'(2'b01); use_rs2 = 1'b1; end
`ifdef CTRL_EXT_OPS_EN
      7'b1101111: begin dec.reg_write = 1'b1; dec.jump = 1'b1; dec.wb_sel = 2'b10; use_rs1 = 1'b0; end
      7'b1100111: begin dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_src = 1'b1; dec.wb_sel = 2'b10; end
      7'b0110111: begin dec.reg_write = 1'b1; dec.wb_sel = 2'b11; use_rs1 = 1'b0; end
      7'b0010111: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; use_rs1 = 1'b0; end
`endif
      default: begin legal = 1'b0; use_rs1 = 1'b0; end
    endcase
    dec.rd = id_rd;
    dec.reg_write = dec.reg_write & |id_rd;
    if (!id_valid || !legal) dec = '0;
  end
  assign hazard = id_valid & id_ex.mem_read & |id_ex.rd &
                  ((use_rs1 & id_ex.rd == id_rs1) | (use_rs2 & id_ex.rd == id_rs2));
  assign stall       = rst_n & ~ex_br_taken & hazard;
  assign flush_if_id = rst_n & ex_br_taken;
  assign id_illegal  = rst_n & id_valid & ~legal;
  assign ex_alu_op    = id_ex.alu_op;
  assign ex_alu_src   = id_ex.alu_src;
  assign ex_branch_en = id_ex.branch;
  assign ex_jump_en   = id_ex.jump;
  assign ex_mem_read  = id_ex.mem_read;
  assign ex_rd        = id_ex.rd;
  // Downstream stages never stall; only ID/EX can be replaced by a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex        <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      em_reg_write <= 1'b0;
      em_wb_sel    <= 2'b00;
      em_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_sel       <= 2'b00;
      wb_rd        <= '0;
      stall_cnt    <= '0;
    end else begin
      id_ex        <= (stall | ex_br_taken) ? '0 : dec;
      mem_read_en  <= id_ex.mem_read;
      mem_write_en <= id_ex.mem_write;
      em_reg_write <= id_ex.reg_write;
      em_wb_sel    <= id_ex.wb_sel;
      em_rd        <= id_ex.rd;
      wb_reg_write <= em_reg_write;
      wb_sel       <= em_wb_sel;
      wb_rd        <= em_rd;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: scoreboard bench for pipe_ctrl_unit (CNT_W=4 build for saturation)
module tb_pipe_ctrl_unit;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
    OP_SW = 7'b0100011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_BAD = 7'b1111111;
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src, branch, jump, mem_read, mem_write, reg_write;
    logic [1:0] wb_sel;
    logic [4:0] rd;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, ex_br_taken = 1'b0;
  logic [6:0] id_opcode = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic stall, flush_if_id, id_illegal, ex_alu_src, ex_branch_en, ex_jump_en, ex_mem_read;
  logic mem_read_en, mem_write_en, wb_reg_write;
  logic [1:0] ex_alu_op, wb_sel;
  logic [4:0] ex_rd, wb_rd;
  logic [3:0] stall_cnt;
  int errors = 0, checks = 0;
  exp_t exq[$], memq[$], wbq[$];
  exp_t prev;
  int cnt;
  pipe_ctrl_unit #(.REG_W(5), .ALU_OP_W(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_br_taken(ex_br_taken),
    .stall(stall), .flush_if_id(flush_if_id), .id_illegal(id_illegal),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch_en(ex_branch_en),
    .ex_jump_en(ex_jump_en), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .wb_reg_write(wb_reg_write),
    .wb_sel(wb_sel), .wb_rd(wb_rd), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic decode(input logic v, input logic [6:0] op, input logic [4:0] rd,
                        output exp_t d, output logic leg, output logic u1, output logic u2);
    d = '0; leg = 1'b1; u1 = 1'b1; u2 = 1'b0;
    case (op)
      OP_R:   begin d.reg_write = 1; d.alu_op = 2'b10; u2 = 1; end
      OP_I:   begin d.reg_write = 1; d.alu_src = 1; d.alu_op = 2'b11; end
      OP_LW:  begin d.mem_read = 1; d.reg_write = 1; d.alu_src = 1; d.wb_sel = 2'b01; end
      OP_SW:  begin d.mem_write = 1; d.alu_src = 1; u2 = 1; end
      OP_BEQ: begin d.branch = 1; d.alu_op = 2'b01; u2 = 1; end
`ifdef CTRL_EXT_OPS_EN
      OP_JAL:   begin d.reg_write = 1; d.jump = 1; d.wb_sel = 2'b10; u1 = 0; end
      OP_JALR:  begin d.reg_write = 1; d.jump = 1; d.alu_src = 1; d.wb_sel = 2'b10; end
      OP_LUI:   begin d.reg_write = 1; d.wb_sel = 2'b11; u1 = 0; end
      OP_AUIPC: begin d.reg_write = 1; d.alu_src = 1; u1 = 0; end
`endif
      default: begin leg = 0; u1 = 0; end
    endcase
    d.rd = rd;
    if (rd == 0) d.reg_write = 0;
    if (!v || !leg) d = '0;
  endtask
  task automatic step(input logic v, input logic [6:0] op, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [4:0] rd, input logic br);
    exp_t d, e, m, w;
    logic leg, u1, u2, st;
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd; ex_br_taken = br;
    decode(v, op, rd, d, leg, u1, u2);
    st = !br && v && prev.mem_read && prev.rd != 0 &&
         ((u1 && prev.rd == r1) || (u2 && prev.rd == r2));
    #1;
    chk("stall", 32'(stall), 32'(st));
    chk("flush_if_id", 32'(flush_if_id), 32'(br));
    chk("id_illegal", 32'(id_illegal), 32'(v && !leg));
    e = (st || br) ? '0 : d;
    prev = e;
    if (st && cnt != 15) cnt++;
    exq.push_back(e); memq.push_back(e); wbq.push_back(e);
    @(posedge clk); #1;
    e = exq.pop_front(); m = memq.pop_front(); w = wbq.pop_front();
    chk("ex_bundle", 32'({ex_alu_op, ex_alu_src, ex_branch_en, ex_jump_en, ex_mem_read, ex_rd}),
        32'({e.alu_op, e.alu_src, e.branch, e.jump, e.mem_read, e.rd}));
    chk("mem_bundle", 32'({mem_read_en, mem_write_en}), 32'({m.mem_read, m.mem_write}));
    chk("wb_bundle", 32'({wb_reg_write, wb_sel, wb_rd}), 32'({w.reg_write, w.wb_sel, w.rd}));
    chk("stall_cnt", 32'(stall_cnt), 32'(cnt));
  endtask
  task automatic do_reset(input logic br);
    rst_n = 1'b0; id_valid = 1'b1; id_opcode = OP_BAD; ex_br_taken = br;
    id_rs1 = 5'd3; id_rs2 = 5'd3; id_rd = 5'd1;
    repeat (2) begin
      #1;
      chk("rst_comb", 32'({stall, flush_if_id, id_illegal}), 32'd0);
      id_opcode = OP_R;
      @(posedge clk); #1;
    end
    chk("rst_regs", 32'({ex_alu_op, ex_alu_src, ex_branch_en, ex_jump_en, ex_mem_read, ex_rd,
        mem_read_en, mem_write_en, wb_reg_write, wb_sel, wb_rd}), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
    exq.delete(); memq.delete(); wbq.delete();
    memq.push_back('0); wbq.push_back('0); wbq.push_back('0);
    prev = '0; cnt = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask
  initial begin
    do_reset(1'b1);
    step(1, OP_R, 5'd1, 5'd2, 5'd5, 0); idle(3);
    step(1, OP_I, 5'd4, 5'd0, 5'd6, 0);
    step(1, OP_LW, 5'd1, 5'd0, 5'd3, 0);
    step(1, OP_R, 5'd3, 5'd2, 5'd7, 0);
    step(1, OP_R, 5'd3, 5'd2, 5'd7, 0); idle(3);
    step(1, OP_LW, 5'd1, 5'd0, 5'd0, 0);
    step(1, OP_R, 5'd0, 5'd0, 5'd7, 0); idle(3);
    step(1, OP_LW, 5'd1, 5'd0, 5'd3, 0);
    step(1, OP_R, 5'd3, 5'd2, 5'd7, 1); idle(3);
    step(1, OP_LW, 5'd1, 5'd0, 5'd3, 0);
    step(1, OP_SW, 5'd1, 5'd3, 5'd0, 0);
    step(1, OP_SW, 5'd1, 5'd3, 5'd0, 0);
    step(1, OP_LW, 5'd1, 5'd0, 5'd3, 0);
    step(1, OP_I, 5'd2, 5'd3, 5'd8, 0);
    step(1, OP_BEQ, 5'd1, 5'd2, 5'd9, 0);
    step(1, OP_JAL, 5'd0, 5'd0, 5'd1, 0);
    step(1, OP_JALR, 5'd2, 5'd0, 5'd1, 0);
    step(1, OP_LUI, 5'd0, 5'd0, 5'd10, 0);
    step(1, OP_AUIPC, 5'd0, 5'd0, 5'd11, 0);
    step(1, OP_BAD, 5'd1, 5'd2, 5'd12, 0);
    step(0, OP_R, 5'd1, 5'd2, 5'd13, 0); idle(3);
    step(1, OP_LW, 5'd1, 5'd0, 5'd3, 0);
    do_reset(1'b0);
    step(1, OP_R, 5'd3, 5'd2, 5'd7, 0); idle(3);
    repeat (40) step(1, OP_LW, 5'd3, 5'd0, 5'd3, 0);
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
